// File: rtl/ddr_out_serializer.sv
// ddr_out_serializer
// Takes BEATS-beat words over a valid/ready handshake and presents them as
// (high-phase, low-phase) beat pairs, one pair per clock, for a DDR output
// primitive. Output enable is held for OE_EXTEND cycles after a burst and the
// forwarded clock is enabled only while a real pair is being shown.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is combinational from state and rst_n and never
// depends on in_valid; in_data must be stable whenever in_valid is high and
// is sampled only at the accepting edge.
module ddr_out_serializer #(
    parameter int WIDTH     = 8,
    parameter int BEATS     = 4,
    parameter int IDLE_HIGH = 0,
    parameter int OE_EXTEND = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH*BEATS-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_h,
    output logic [WIDTH-1:0]       out_l,
    output logic                   out_oe,
    output logic                   out_clken,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int PAIRS = BEATS / 2;
    localparam int TOT   = WIDTH * BEATS;
    localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);
    localparam logic [3:0]       TAIL_INIT = (OE_EXTEND > 0) ? 4'(OE_EXTEND - 1) : 4'd0;
    localparam logic [WIDTH-1:0] IDLE_VAL  = (IDLE_HIGH != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    // Reject parameter sets the datapath cannot represent.
    generate
        if ((BEATS < 2) || ((BEATS % 2) != 0)) begin : g_bad_beats
            $error("ddr_out_serializer: BEATS must be even and at least 2");
        end
        if ((OE_EXTEND < 0) || (OE_EXTEND > 15)) begin : g_bad_oe
            $error("ddr_out_serializer: OE_EXTEND must be in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [CNT_W-1:0]   r_pair_cnt, w_pair_cnt_nxt;
    logic [3:0]         r_tail_cnt, w_tail_cnt_nxt;
    logic [TOT-1:0]     r_word,     w_word_nxt;
    logic [WIDTH-1:0]   r_out_h,    w_out_h_nxt;
    logic [WIDTH-1:0]   r_out_l,    w_out_l_nxt;
    logic               r_oe,       w_oe_nxt;
    logic               r_clken,    w_clken_nxt;

    logic               w_accept;
    logic [2*WIDTH-1:0] w_first_pair;
    logic [2*WIDTH-1:0] w_next_pair;

    // Pick pair idx (beats 2*idx and 2*idx+1) out of a word; low beat of the
    // pair goes to the high phase.
    function automatic logic [2*WIDTH-1:0] pair_sel(input logic [TOT-1:0]   word,
                                                    input logic [CNT_W-1:0] idx);
        logic [2*WIDTH-1:0] sel;
        sel = '0;
        for (int p = 0; p < PAIRS; p++) begin
            if (idx == CNT_W'(p)) begin
                sel = word[p*2*WIDTH +: 2*WIDTH];
            end
        end
        return sel;
    endfunction

    assign in_ready     = rst_n & ((r_state != ST_SHIFT) | (r_pair_cnt == LAST_PAIR));
    assign w_accept     = in_valid & in_ready;
    assign w_first_pair = in_data[2*WIDTH-1:0];
    assign w_next_pair  = pair_sel(r_word, r_pair_cnt + CNT_W'(1));

    // Next-state and next-output logic; every output defaults to idle.
    always_comb begin
        w_state_nxt    = r_state;
        w_pair_cnt_nxt = r_pair_cnt;
        w_tail_cnt_nxt = r_tail_cnt;
        w_word_nxt     = r_word;
        w_out_h_nxt    = IDLE_VAL;
        w_out_l_nxt    = IDLE_VAL;
        w_oe_nxt       = 1'b0;
        w_clken_nxt    = 1'b0;

        if (w_accept) begin
            // A new word always starts the same way, whether from IDLE,
            // from TAIL, or gaplessly after the last pair.
            w_state_nxt    = ST_SHIFT;
            w_pair_cnt_nxt = '0;
            w_tail_cnt_nxt = '0;
            w_word_nxt     = in_data;
            w_out_h_nxt    = w_first_pair[WIDTH-1:0];
            w_out_l_nxt    = w_first_pair[2*WIDTH-1:WIDTH];
            w_oe_nxt       = 1'b1;
            w_clken_nxt    = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (r_pair_cnt != LAST_PAIR) begin
                        w_pair_cnt_nxt = r_pair_cnt + CNT_W'(1);
                        w_out_h_nxt    = w_next_pair[WIDTH-1:0];
                        w_out_l_nxt    = w_next_pair[2*WIDTH-1:WIDTH];
                        w_oe_nxt       = 1'b1;
                        w_clken_nxt    = 1'b1;
                    end else if (OE_EXTEND > 0) begin
                        w_state_nxt    = ST_TAIL;
                        w_tail_cnt_nxt = TAIL_INIT;
                        w_oe_nxt       = 1'b1;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                    end
                end
                ST_TAIL: begin
                    if (r_tail_cnt == 4'd0) begin
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_tail_cnt_nxt = r_tail_cnt - 4'd1;
                        w_oe_nxt       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters, word store and registered pad outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pair_cnt <= '0;
            r_tail_cnt <= '0;
            r_word     <= '0;
            r_out_h    <= IDLE_VAL;
            r_out_l    <= IDLE_VAL;
            r_oe       <= 1'b0;
            r_clken    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pair_cnt <= w_pair_cnt_nxt;
            r_tail_cnt <= w_tail_cnt_nxt;
            r_word     <= w_word_nxt;
            r_out_h    <= w_out_h_nxt;
            r_out_l    <= w_out_l_nxt;
            r_oe       <= w_oe_nxt;
            r_clken    <= w_clken_nxt;
        end
    end

    assign out_h     = r_out_h;
    assign out_l     = r_out_l;
    assign out_oe    = r_oe;
    assign out_clken = r_clken;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule
